// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// The optional fetch address alignment check is enabled by FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// One request outstanding: valid/addr_ok for the request, data_ok for the response.
interface fetch_if;

  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {instr, pc, exc} while decode is stalled.
// Write has priority over read; the stage never does both in the same cycle.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr,
  input  logic         rd,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty
);

  fetch_entry_t data;
  logic         full;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr) begin
      data <= din;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

  assign dout  = data;
  assign empty = !full;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC generation, ibus handshake, output register + skid,
// branch redirect with delay slot. Macro FETCH_ALIGN_CHECK_EN enables the alignment check.
//
// state  | meaning
// S_IDLE | after reset, no request
// S_REQ  | request for pcF on the bus
// S_WAIT | request accepted, waiting for data_ok
// S_FULL | skid holds a word, waiting for decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_if.master       ibus,
  input  logic          stallD,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic          validD,
  output logic          excD
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_f;
  logic [31:0]  pc_adv;
  logic         pend_valid;
  logic [31:0]  pend_pc;
  logic         valid_d;
  logic [31:0]  instr_d;
  logic [31:0]  pc_d;
  logic         exc_d;

  logic         misaligned;
  logic         req_valid;
  logic         complete;
  logic [31:0]  resp_instr;
  logic         resp_exc;
  logic         load;
  fetch_entry_t load_entry;
  fetch_entry_t resp_entry;
  logic         skid_wr;
  logic         skid_rd;
  logic         skid_empty;
  fetch_entry_t skid_dout;
  logic         redirect_acc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc_f[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign redirect_acc = valid_d && !stallD && redirect_valid;
  assign pc_adv = redirect_acc ? redirect_pc :
                  pend_valid   ? pend_pc     : pc_f + 32'd4;

  assign resp_entry.instr = resp_instr;
  assign resp_entry.pc    = pc_f;
  assign resp_entry.exc   = resp_exc;

  always_comb begin
    state_nxt  = state;
    req_valid  = 1'b0;
    complete   = 1'b0;
    resp_instr = ibus.iresp_data;
    resp_exc   = 1'b0;
    load       = 1'b0;
    load_entry = resp_entry;
    skid_wr    = 1'b0;
    skid_rd    = 1'b0;

    case (state)
      S_IDLE: begin
        if (skid_empty) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (misaligned) begin
          // Faulting fetch never reaches the bus; deliver a NOP tagged with the exception.
          complete   = 1'b1;
          resp_instr = NOP_INSTR;
          resp_exc   = 1'b1;
        end else begin
          req_valid = 1'b1;
          if (ibus.iresp_addr_ok && ibus.iresp_data_ok) complete = 1'b1;
          else if (ibus.iresp_addr_ok)                  state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ibus.iresp_data_ok) complete = 1'b1;
      end
      S_FULL: begin
        if (!stallD) begin
          skid_rd    = 1'b1;
          load       = 1'b1;
          load_entry = skid_dout;
          state_nxt  = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (complete) begin
      if (!valid_d || !stallD) begin
        load      = 1'b1;
        state_nxt = S_REQ;
      end else begin
        skid_wr   = 1'b1;
        state_nxt = S_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pc_f       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      valid_d    <= 1'b0;
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      exc_d      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        instr_d    <= load_entry.instr;
        pc_d       <= load_entry.pc;
        exc_d      <= load_entry.exc;
        valid_d    <= 1'b1;
        pc_f       <= pc_adv;
        pend_valid <= 1'b0;
      end else begin
        if (valid_d && !stallD) valid_d <= 1'b0;
        // Target accepted with no advance this cycle: hold it until the delay slot loads.
        if (redirect_acc) begin
          pend_valid <= 1'b1;
          pend_pc    <= redirect_pc;
        end
      end
    end
  end

  fetch_skid u_skid (
    .clk    (clk),
    .resetn (resetn),
    .wr     (skid_wr),
    .rd     (skid_rd),
    .din    (resp_entry),
    .dout   (skid_dout),
    .empty  (skid_empty)
  );

  assign ibus.ireq_valid = req_valid;
  assign ibus.ireq_addr  = pc_f;
  assign instrD          = instr_d;
  assign pcD             = pc_d;
  assign validD          = valid_d;
  assign excD            = exc_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected deliveries,
// a negedge monitor pops and compares every instruction decode consumes.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stallD = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        excD;

  fetch_if ibus ();

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ibus           (ibus),
    .stallD         (stallD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instrD         (instrD),
    .pcD            (pcD),
    .validD         (validD),
    .excD           (excD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // instruction memory model: data_ok lat cycles after addr_ok (0 = same cycle)
  int          lat = 0;
  logic        accept_en = 1'b1;
  logic        inject_dok = 1'b0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] busy_addr = 32'h0;

  always_comb begin
    ibus.iresp_addr_ok = ibus.ireq_valid && accept_en && !busy;
    ibus.iresp_data_ok = (ibus.iresp_addr_ok && lat == 0) || (busy && cnt == 0) || inject_dok;
    ibus.iresp_data    = mem_word(busy ? busy_addr : ibus.ireq_addr);
  end

  always @(posedge clk) begin
    if (!resetn) begin
      busy <= 1'b0;
    end else if (ibus.iresp_addr_ok && lat > 0) begin
      busy      <= 1'b1;
      cnt       <= lat - 1;
      busy_addr <= ibus.ireq_addr;
    end else if (busy) begin
      if (cnt == 0) busy <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    e.exc   = 1'b0;
    sb.push_back(e);
  endfunction

  function automatic void push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) push_pc(start + 32'(4 * i));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetn && validD && !stallD) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery", pcD);
      end else begin
        e = sb.pop_front();
        check32("sb_pc", pcD, e.pc);
        check32("sb_instr", instrD, e.instr);
        check32("sb_exc", {31'b0, excD}, {31'b0, e.exc});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    stallD = 1'b0;
    redirect_valid = 1'b0;
    inject_dok = 1'b0;
    accept_en = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic drain_and_freeze(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    stallD = 1'b1;
    redirect_valid = 1'b0;
    check32(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_pcd(input logic [31:0] pc, output bit found);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (validD && pcD == pc) begin
        found = 1'b1;
        break;
      end
    end
    check32("wait_pcd", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_aok(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ibus.ireq_valid && ibus.iresp_addr_ok) begin
        found = 1'b1;
        break;
      end
    end
    check32("wait_addr_ok", {31'b0, found}, 32'd1);
  endtask

  task automatic run_stall(input bit redir_at_release);
    bit found;
    lat = 0;
    do_reset();
    if (redir_at_release) begin
      push_seq(32'hBFC0_0000, 4);
      push_seq(32'hBFC0_0300, 2);
    end else begin
      push_seq(32'hBFC0_0000, 6);
    end
    wait_pcd(32'hBFC0_0008, found);
    stallD = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hDEAD_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check32("stall_no_req", {31'b0, ibus.ireq_valid}, 32'd0);
      check32("stall_pcd", pcD, 32'hBFC0_0008);
      check32("stall_instrd", instrD, 32'h0008_FFF7);
    end
    @(posedge clk);
    #1;
    stallD = 1'b0;
    redirect_valid = redir_at_release;
    redirect_pc = 32'hBFC0_0300;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain_and_freeze(redir_at_release ? "drain_skid_redirect" : "drain_stall");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    bit found;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_validD", {31'b0, validD}, 32'd0);
    check32("rst_instrD", instrD, 32'h0);
    check32("rst_pcD", pcD, 32'h0);
    check32("rst_excD", {31'b0, excD}, 32'd0);
    check32("rst_ireq_valid", {31'b0, ibus.ireq_valid}, 32'd0);
    check32("rst_ireq_addr", ibus.ireq_addr, 32'hBFC0_0000);

    // back-to-back single-cycle requests
    lat = 0;
    do_reset();
    push_seq(32'hBFC0_0000, 6);
    @(negedge clk);
    check32("idle_no_req", {31'b0, ibus.ireq_valid}, 32'd0);
    @(negedge clk);
    check32("req0_valid", {31'b0, ibus.ireq_valid}, 32'd1);
    check32("req0_addr", ibus.ireq_addr, 32'hBFC0_0000);
    check32("req0_validD", {31'b0, validD}, 32'd0);
    @(negedge clk);
    check32("req1_addr", ibus.ireq_addr, 32'hBFC0_0004);
    check32("first_validD", {31'b0, validD}, 32'd1);
    @(negedge clk);
    check32("req2_addr", ibus.ireq_addr, 32'hBFC0_0008);
    drain_and_freeze("drain_stream");

    // addr_ok at t, data_ok at t+3
    lat = 3;
    do_reset();
    push_seq(32'hBFC0_0000, 2);
    wait_aok(found);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("wait_no_req", {31'b0, ibus.ireq_valid}, 32'd0);
    end
    @(negedge clk);
    check32("lat_validD", {31'b0, validD}, 32'd1);
    check32("lat_instrD", instrD, 32'h0000_FFFF);
    check32("lat_pcD", pcD, 32'hBFC0_0000);
    drain_and_freeze("drain_latency");

    // taken branch at BFC00010: delay slot, then target
    lat = 0;
    do_reset();
    push_seq(32'hBFC0_0000, 6);
    push_seq(32'hBFC0_0100, 2);
    wait_pcd(32'hBFC0_0010, found);
    redirect_valid = 1'b1;
    redirect_pc = 32'hBFC0_0100;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain_and_freeze("drain_redirect");

    // stall with skid capture; redirect during stall ignored
    run_stall(1'b0);
    // redirect while skid holds the delay slot
    run_stall(1'b1);

    // redirect while the delay slot is still in flight goes through the pending register
    lat = 3;
    do_reset();
    push_seq(32'hBFC0_0000, 3);
    push_seq(32'hBFC0_0200, 2);
    wait_pcd(32'hBFC0_0004, found);
    redirect_valid = 1'b1;
    redirect_pc = 32'hBFC0_0200;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain_and_freeze("drain_pending");

    // reset during S_WAIT, stray data_ok in S_IDLE
    lat = 5;
    do_reset();
    wait_aok(found);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    sb.delete();
    lat = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    inject_dok = 1'b1;
    @(posedge clk);
    #1;
    inject_dok = 1'b0;
    push_seq(32'hBFC0_0000, 2);
    @(negedge clk);
    check32("rr_ireq_valid", {31'b0, ibus.ireq_valid}, 32'd1);
    check32("rr_ireq_addr", ibus.ireq_addr, 32'hBFC0_0000);
    check32("rr_validD", {31'b0, validD}, 32'd0);
    @(negedge clk);
    check32("rr_first_validD", {31'b0, validD}, 32'd1);
    drain_and_freeze("drain_reset");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of decode.
- Generates the PC and runs the ibus valid/addr_ok/data_ok handshake with one request outstanding.
- Delivers an (instr, pc, valid) triple to decode through an output register plus a 1-entry skid buffer.
- Takes the branch/jump redirect from decode and honours the MIPS branch delay slot.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetch after reset.

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  synchronous reset, active-low.
- ireq_valid  out  1  ibus request valid.
- ireq_addr  out  32  ibus request address; equals pcF.
- iresp_addr_ok  in  1  request accepted this cycle.
- iresp_data_ok  in  1  instruction data valid this cycle.
- iresp_data  in  32  instruction word.
- stallD  in  1  decode cannot consume this cycle.
- redirect_valid  in  1  decode taken branch/jump.
- redirect_pc  in  32  branch/jump target.
- instrD  out  32  instruction to decode.
- pcD  out  32  pc of instrD.
- validD  out  1  instrD/pcD hold a real instruction.
- excD  out  1  fetch address error (see Optional Feature).

Behaviour:
- Clock is clk; reset is resetn, synchronous and active-low.
- Reset values:
  - state = S_IDLE, pcF = RESET_PC.
  - validD = 0, instrD = 0, pcD = 0, excD = 0.
  - skid empty, redirect pending flag = 0, ireq_valid = 0.
- pcF is the address of the oldest instruction not yet loaded into the output register.
- pcF advances only when an instruction enters the output register, never on data_ok alone.
- Next pc on advance:
  - redirect_pc if redirect is accepted in the same cycle;
  - else the pending target if the pending flag is set (flag clears);
  - else pcF+4 (32-bit wrap).
- Redirect accept:
  - redirect_valid is sampled only when validD && !stallD; ignored otherwise.
  - At acceptance pcF = branch pc + 4 (the delay slot), so the delay slot is always fetched and delivered.
  - The target applies to the next advance.
  - If no advance happens that cycle, the target is latched in the pending register.
- FSM:
  - S_IDLE: ireq_valid = 0. Goes to S_REQ the next cycle.
  - S_REQ: ireq_valid = 1, ireq_addr = pcF.
    - addr_ok && data_ok → complete.
    - addr_ok only → S_WAIT.
    - Else stay in S_REQ; address is held stable.
    - Enter S_REQ only when the skid is empty.
  - S_WAIT: ireq_valid = 0. On data_ok → complete.
- Complete:
  - If validD == 0 or !stallD: load instrD/pcD, validD = 1, advance pcF, go to S_REQ.
  - Else write the skid and go to S_FULL.
- S_FULL: no request. When !stallD: skid → output register, advance pcF, skid empty, go to S_REQ.
- Consumption: validD && !stallD with no new load in the same cycle → validD = 0.
- Output register holds its value unchanged while stallD = 1.
- Reset mid-operation:
  - Returns to S_IDLE and drops any in-flight response.
  - data_ok while in S_IDLE is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined, and pcF[1:0] != 0 in S_REQ:
  - no bus request is issued (ireq_valid = 0);
  - the stage completes immediately with instr = 32'h0 and excD = 1, otherwise the normal flow.
- Undefined: excD is tied 0 and the address is issued unchecked.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_REQ, S_WAIT, S_FULL};
  - RESET_PC default constant;
  - NOP_INSTR = 32'h0.
- One sub-module, fetch_skid: 1-entry buffer with {instr, pc, exc}, write/read/empty.

Test Plan:
- Reset, then addr_ok and data_ok both set every cycle → ireq_addr sequence BFC00000, BFC00004, BFC00008; validD rises 1 cycle after the first data_ok; one instruction is delivered per 1-cycle request.
- addr_ok at cycle t, data_ok at t+3 → ireq_valid deasserted during t+1..t+3; instrD = iresp_data at t+4; pcD correct.
- Branch at pcD = BFC00010, redirect_valid = 1, redirect_pc = BFC00100, stallD = 0 → next delivered pcD = BFC00014 (delay slot), then BFC00100.
- stallD = 1 for 5 cycles while data_ok returns → skid captures the word, no new request, instrD stable; after release the skid word is delivered, then fetch resumes at pc+4.
- redirect_valid asserted while stallD = 1 → ignored; asserted while skid full → target latched pending and applied after the delay slot drains.
- resetn low during S_WAIT, data_ok arrives the next cycle → ignored; first request after release is at BFC00000, validD = 0 until it returns.
